// File: rtl/game_sequencer_if.sv
// Player-facing and timer-facing signals of the game sequencer, grouped into one bundle.
// The slave modport is the sequencer's view; master is the driver/observer side.
interface game_sequencer_if;
  logic        start_btn;
  logic        hit;
  logic        miss;
  logic        game_over_in;
  logic        timer_rst;
  logic        timer_start;
  logic        timer_miss;
  logic [1:0]  state;
  logic [3:0]  ready_digit;
  logic [15:0] score;
  logic [15:0] best;

  modport slave (
    input  start_btn, hit, miss, game_over_in,
    output timer_rst, timer_start, timer_miss, state, ready_digit, score, best
  );

  modport master (
    output start_btn, hit, miss, game_over_in,
    input  timer_rst, timer_start, timer_miss, state, ready_digit, score, best
  );
endinterface

// File: rtl/game_sequencer.sv
// Reaction-game sequencer: IDLE -> READY countdown 3..1 -> PLAY (BCD scoring) -> OVER.
// Drives single-cycle reset/start/penalty pulses to an external countdown timer.
module game_sequencer #(
  parameter int TICK_DIV    = 50000,
  parameter int READY_TICKS = 1000
) (
  input logic             clock,
  input logic             reset,
  game_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_READY = 2'b01;
  localparam logic [1:0] S_PLAY  = 2'b10;
  localparam logic [1:0] S_OVER  = 2'b11;

  localparam int TW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int RW = (READY_TICKS > 1) ? $clog2(READY_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] READY_LAST = RW'(READY_TICKS - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    digit_q, digit_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   best_q, best_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [RW-1:0] tick_num_q, tick_num_d;
  logic          btn_q, btn_d;
  logic          armed_q, armed_d;
  logic          over_new_q, over_new_d;
  logic          rst_p_q, rst_p_d;
  logic          start_p_q, start_p_d;
  logic          miss_p_q, miss_p_d;
  logic          start_edge, tick;

  // Ripple +1 across four BCD digits; caller handles 9999 saturation.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // armed_q stays low after reset until the button is seen released, so a
  // button held through reset release cannot fake an edge.
  assign start_edge = bus.start_btn & ~btn_q & armed_q;
  assign tick       = (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    score_d     = score_q;
    best_d      = best_q;
    tick_cnt_d  = '0;
    tick_num_d  = '0;
    btn_d       = bus.start_btn;
    armed_d     = armed_q | ~bus.start_btn;
    over_new_d  = 1'b0;
    rst_p_d     = 1'b0;
    start_p_d   = 1'b0;
    miss_p_d    = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          state_d = S_READY;
          digit_d = 4'd3;
          score_d = '0;
          rst_p_d = 1'b1;
        end
      end
      S_READY: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        tick_num_d = tick_num_q;
        if (tick) begin
          if (tick_num_q == READY_LAST) begin
            tick_num_d = '0;
            if (digit_q == 4'd1) begin
              state_d   = S_PLAY;
              digit_d   = 4'd0;
              start_p_d = 1'b1;
            end else begin
              digit_d = digit_q - 4'd1;
            end
          end else begin
            tick_num_d = tick_num_q + 1'b1;
          end
        end
      end
      default: begin
        if (bus.game_over_in) begin
          state_d    = S_OVER;
          over_new_d = 1'b1;
        end else if (bus.miss) begin
          miss_p_d = 1'b1;
        end else if (bus.hit && score_q != 16'h9999) begin
          score_d = bcd_inc(score_q);
        end
      end
    endcase

    // Packed BCD orders the same as binary, so a plain compare suffices.
    if (state_q == S_OVER && over_new_q && score_q > best_q)
      best_d = score_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      digit_q    <= '0;
      score_q    <= '0;
      best_q     <= '0;
      tick_cnt_q <= '0;
      tick_num_q <= '0;
      btn_q      <= 1'b0;
      armed_q    <= 1'b0;
      over_new_q <= 1'b0;
      rst_p_q    <= 1'b0;
      start_p_q  <= 1'b0;
      miss_p_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      score_q    <= score_d;
      best_q     <= best_d;
      tick_cnt_q <= tick_cnt_d;
      tick_num_q <= tick_num_d;
      btn_q      <= btn_d;
      armed_q    <= armed_d;
      over_new_q <= over_new_d;
      rst_p_q    <= rst_p_d;
      start_p_q  <= start_p_d;
      miss_p_q   <= miss_p_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.ready_digit = digit_q;
  assign bus.score       = score_q;
  assign bus.best        = best_q;
  assign bus.timer_rst   = rst_p_q;
  assign bus.timer_start = start_p_q;
  assign bus.timer_miss  = miss_p_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: an integer-score, elapsed-cycle model checked every
// cycle, plus directed games with hand-computed literal expectations.
module tb_game_sequencer;
  localparam int TD = 4;
  localparam int RT = 2;
  localparam int DIGIT_CYC = TD * RT;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  game_sequencer_if bus_if();

  game_sequencer #(.TICK_DIV(TD), .READY_TICKS(RT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // Model: state as a number, score/best as plain integers, countdown from elapsed cycles.
  int   m_state, m_elapsed, m_score, m_best;
  logic m_prev, m_armed, m_over_first, m_rst_p, m_start_p, m_miss_p;
  logic m_edge;
  assign m_edge = bus_if.start_btn & ~m_prev & m_armed;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_elapsed <= 0; m_score <= 0; m_best <= 0;
      m_prev <= 1'b0; m_armed <= 1'b0; m_over_first <= 1'b0;
      m_rst_p <= 1'b0; m_start_p <= 1'b0; m_miss_p <= 1'b0;
    end else begin
      m_prev       <= bus_if.start_btn;
      m_armed      <= m_armed | ~bus_if.start_btn;
      m_rst_p      <= 1'b0;
      m_start_p    <= 1'b0;
      m_miss_p     <= 1'b0;
      m_over_first <= (m_state == 2) && bus_if.game_over_in;
      if (m_state == 3 && m_over_first && m_score > m_best) m_best <= m_score;
      if (m_state == 0 || m_state == 3) begin
        if (m_edge) begin
          m_state <= 1; m_elapsed <= 0; m_score <= 0; m_rst_p <= 1'b1;
        end
      end else if (m_state == 1) begin
        m_elapsed <= m_elapsed + 1;
        if (m_elapsed + 1 == 3 * DIGIT_CYC) begin
          m_state <= 2; m_start_p <= 1'b1;
        end
      end else begin
        if (bus_if.game_over_in) m_state <= 3;
        else if (bus_if.miss) m_miss_p <= 1'b1;
        else if (bus_if.hit) m_score <= (m_score >= 9999) ? 9999 : m_score + 1;
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] m_digit();
    return (m_state == 1) ? 4'(3 - m_elapsed / DIGIT_CYC) : 4'd0;
  endfunction

  always @(negedge clock) begin
    checks++;
    if (bus_if.state !== 2'(m_state) || bus_if.ready_digit !== m_digit() ||
        bus_if.score !== to_bcd(m_score) || bus_if.best !== to_bcd(m_best) ||
        bus_if.timer_rst !== m_rst_p || bus_if.timer_start !== m_start_p ||
        bus_if.timer_miss !== m_miss_p) begin
      errors++;
      $display("FAIL model_cmp t=%0t got st=%0d dg=%0d sc=%h bs=%h p=%b%b%b want st=%0d dg=%0d sc=%h bs=%h p=%b%b%b",
               $time, bus_if.state, bus_if.ready_digit, bus_if.score, bus_if.best,
               bus_if.timer_rst, bus_if.timer_start, bus_if.timer_miss,
               m_state, m_digit(), to_bcd(m_score), to_bcd(m_best), m_rst_p, m_start_p, m_miss_p);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
    int n = 0;
    while (bus_if.state !== s && n < budget) begin
      step();
      n++;
    end
    expect_val(nm, {14'd0, bus_if.state}, {14'd0, s});
  endtask

  task automatic press_start();
    bus_if.start_btn = 1'b1;
    step();
    expect_val("start_rst_pulse", {15'd0, bus_if.timer_rst}, 16'd1);
    expect_val("start_digit3", {12'd0, bus_if.ready_digit}, 16'd3);
    bus_if.start_btn = 1'b0;
  endtask

  task automatic start_game();
    press_start();
    wait_state(2'b10, 40, "reach_play");
    expect_val("play_start_pulse", {15'd0, bus_if.timer_start}, 16'd1);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.hit = 1'b1; step();
      bus_if.hit = 1'b0; step();
    end
  endtask

  task automatic end_game();
    bus_if.game_over_in = 1'b1; bus_if.hit = 1'b1;
    step();
    bus_if.game_over_in = 1'b0; bus_if.hit = 1'b0;
    expect_val("over_state", {14'd0, bus_if.state}, 16'd3);
    step(); step();
  endtask

  initial begin
    bus_if.start_btn = 1'b0; bus_if.hit = 1'b0;
    bus_if.miss = 1'b0; bus_if.game_over_in = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    expect_val("reset_state", {14'd0, bus_if.state}, 16'd0);
    expect_val("reset_score", bus_if.score, 16'h0000);

    // Countdown timing: digit 3 for 8 clocks, then 2; inputs ignored in READY.
    press_start();
    bus_if.hit = 1'b1; bus_if.miss = 1'b1; bus_if.game_over_in = 1'b1;
    for (int i = 0; i < 7; i++) step();
    bus_if.hit = 1'b0; bus_if.miss = 1'b0; bus_if.game_over_in = 1'b0;
    expect_val("digit3_hold", {12'd0, bus_if.ready_digit}, 16'd3);
    step();
    expect_val("digit2", {12'd0, bus_if.ready_digit}, 16'd2);
    bus_if.start_btn = 1'b1; step(); bus_if.start_btn = 1'b0;
    wait_state(2'b10, 40, "reach_play1");
    expect_val("play_start_pulse1", {15'd0, bus_if.timer_start}, 16'd1);
    hits(5);
    expect_val("score5", bus_if.score, 16'h0005);
    end_game();
    expect_val("best5", bus_if.best, 16'h0005);

    // Game 2: 12 hits, hit+miss, three back-to-back misses.
    start_game();
    hits(12);
    expect_val("score12", bus_if.score, 16'h0012);
    bus_if.hit = 1'b1; bus_if.miss = 1'b1; step();
    bus_if.hit = 1'b0; bus_if.miss = 1'b0;
    expect_val("hitmiss_pulse", {15'd0, bus_if.timer_miss}, 16'd1);
    expect_val("hitmiss_score", bus_if.score, 16'h0012);
    bus_if.miss = 1'b1; step(); step(); step();
    bus_if.miss = 1'b0;
    expect_val("miss3_pulse", {15'd0, bus_if.timer_miss}, 16'd1);
    step();
    expect_val("miss_done", {15'd0, bus_if.timer_miss}, 16'd0);
    end_game();
    expect_val("best12", bus_if.best, 16'h0012);

    // Game 3: lower score keeps best.
    start_game();
    hits(3);
    end_game();
    expect_val("score3", bus_if.score, 16'h0003);
    expect_val("best_kept", bus_if.best, 16'h0012);

    // Game 4: saturate at 9999.
    start_game();
    bus_if.hit = 1'b1;
    for (int i = 0; i < 10000; i++) step();
    bus_if.hit = 1'b0;
    expect_val("score_sat", bus_if.score, 16'h9999);
    end_game();
    expect_val("best_sat", bus_if.best, 16'h9999);

    // Reset mid-READY with the button held through release.
    press_start();
    wait_state(2'b01, 2, "ready_again");
    for (int i = 0; i < DIGIT_CYC; i++) step();
    expect_val("mid_digit2", {12'd0, bus_if.ready_digit}, 16'd2);
    bus_if.start_btn = 1'b1;
    #2 reset = 1'b1;
    #1;
    expect_val("async_state", {14'd0, bus_if.state}, 16'd0);
    expect_val("async_digit", {12'd0, bus_if.ready_digit}, 16'd0);
    expect_val("async_pulses", {13'd0, bus_if.timer_rst, bus_if.timer_start, bus_if.timer_miss}, 16'd0);
    expect_val("async_best", bus_if.best, 16'h0000);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    expect_val("held_btn_idle", {14'd0, bus_if.state}, 16'd0);
    bus_if.start_btn = 1'b0; step();
    press_start();
    expect_val("rearm_ready", {14'd0, bus_if.state}, 16'd1);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
